inc_chain_pipe: RTL and testbench

- Three-stage registered increment chain: captures x, then computes y = x + INC, then z = y + INC, one stage per clock.
- Sits directly downstream of the free-running x/y/z sequencing logic. Consumes a stream of x values and presents the completed (x, y, z) triple to the consumer.
- Uses valid/ready handshakes on both sides. Sustains full throughput of one triple per cycle and holds data under backpressure.

---
 rtl/inc_chain_pipe_pkg.sv | 15 +
 rtl/inc_chain_pipe_inc.sv | 68 ++++++
 rtl/inc_chain_pipe.sv | 98 +++++++++
 tb/tb_inc_chain_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/inc_chain_pipe_pkg.sv
// Shared types and constants for the x/y/z increment chain.
// Stage record, default datapath width and occupancy width.
package inc_chain_pipe_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int OCC_W     = 2;

   typedef struct packed {
      logic [WIDTH_DEF-1:0] x;
      logic [WIDTH_DEF-1:0] y;
      logic [WIDTH_DEF-1:0] z;
      logic                 wrap;
   } stage_t;

endpackage

// File: rtl/inc_chain_pipe_inc.sv
// inc_stage: valid/ready register slice with an increment adder.
// Carries a pass-through field plus sum and sticky carry.
module inc_stage
   import inc_chain_pipe_pkg::*;
#(
   parameter int               WIDTH = WIDTH_DEF,
   parameter int               PW    = WIDTH,
   parameter logic [WIDTH-1:0] INC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vld_i,
   output logic             rdy_o,
   input  logic             dn_rdy_i,
   input  logic [PW-1:0]    pass_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic             w_i,
   output logic             vld_o,
   output logic [PW-1:0]    pass_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             w_o
);

   logic             v_q, v_d;
   logic [PW-1:0]    pass_q, pass_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             w_q, w_d;
   logic [WIDTH:0]   add;
   logic             ld;

   assign rdy_o = !v_q || dn_rdy_i;
   assign ld    = rdy_o && vld_i;
   assign add   = {1'b0, a_i} + {1'b0, INC};

   // data only moves with a valid item so an empty slice keeps its last value
   always_comb begin
      v_d    = v_q;
      pass_d = pass_q;
      sum_d  = sum_q;
      w_d    = w_q;
      if (rdy_o) v_d = vld_i;
      if (ld) begin
         pass_d = pass_i;
         sum_d  = add[WIDTH-1:0];
         w_d    = w_i | add[WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q    <= 1'b0;
         pass_q <= '0;
         sum_q  <= '0;
         w_q    <= 1'b0;
      end else begin
         v_q    <= v_d;
         pass_q <= pass_d;
         sum_q  <= sum_d;
         w_q    <= w_d;
      end
   end

   assign vld_o  = v_q;
   assign pass_o = pass_q;
   assign sum_o  = sum_q;
   assign w_o    = w_q;

endmodule

// File: rtl/inc_chain_pipe.sv
// Three-stage x -> y=x+INC -> z=y+INC pipeline with valid/ready.
// S1 is a plain slice; S2 and S3 are inc_stage instances.
module inc_chain_pipe
   import inc_chain_pipe_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int INC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic [WIDTH-1:0] out_z,
   output logic             out_wrap,
   output logic [OCC_W-1:0] occupancy
);

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   logic               v1_q, v1_d;
   logic [WIDTH-1:0]   x1_q, x1_d;
   logic               r1, r2, r3;
   logic               v2;
   logic [WIDTH-1:0]   x2, y2;
   logic               w2;
   logic [2*WIDTH-1:0] xy3;

   assign r1       = !v1_q || r2;
   assign in_ready = r1;

   always_comb begin
      v1_d = v1_q;
      x1_d = x1_q;
      if (r1) begin
         v1_d = in_valid;
         if (in_valid) x1_d = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q <= 1'b0;
         x1_q <= '0;
      end else begin
         v1_q <= v1_d;
         x1_q <= x1_d;
      end
   end

   inc_stage #(
      .WIDTH (WIDTH),
      .PW    (WIDTH),
      .INC   (INC_W)
   ) u_s2 (
      .clk      (clk),
      .reset    (reset),
      .vld_i    (v1_q),
      .rdy_o    (r2),
      .dn_rdy_i (r3),
      .pass_i   (x1_q),
      .a_i      (x1_q),
      .w_i      (1'b0),
      .vld_o    (v2),
      .pass_o   (x2),
      .sum_o    (y2),
      .w_o      (w2)
   );

   inc_stage #(
      .WIDTH (WIDTH),
      .PW    (2*WIDTH),
      .INC   (INC_W)
   ) u_s3 (
      .clk      (clk),
      .reset    (reset),
      .vld_i    (v2),
      .rdy_o    (r3),
      .dn_rdy_i (out_ready),
      .pass_i   ({x2, y2}),
      .a_i      (y2),
      .w_i      (w2),
      .vld_o    (out_valid),
      .pass_o   (xy3),
      .sum_o    (out_z),
      .w_o      (out_wrap)
   );

   assign out_x = xy3[2*WIDTH-1:WIDTH];
   assign out_y = xy3[WIDTH-1:0];

   assign occupancy = OCC_W'(v1_q) + OCC_W'(v2) + OCC_W'(out_valid);

endmodule

// File: tb/tb_inc_chain_pipe.sv
// Bench for inc_chain_pipe: directed cycle table, then random
// traffic checked against a queue-based reference model.
module tb_inc_chain_pipe;
   import inc_chain_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_x, out_y, out_z;
   logic        out_wrap;
   logic [1:0]  occupancy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inc_chain_pipe #(.WIDTH(32), .INC(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_z     (out_z),
      .out_wrap  (out_wrap),
      .occupancy (occupancy)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        eir;
      logic        eov;
      logic [1:0]  eocc;
      logic        cd;
      logic [31:0] ex, ey, ez;
      logic        ew;
   } vec_t;

   vec_t   tv[$];
   stage_t mq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic iv, input logic [31:0] d,
                      input logic ordy, input logic eir, input logic eov,
                      input logic [1:0] eocc, input logic cd,
                      input logic [31:0] ex, input logic [31:0] ey,
                      input logic [31:0] ez, input logic ew);
      vec_t v;
      v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy;
      v.eir = eir; v.eov = eov; v.eocc = eocc; v.cd = cd;
      v.ex = ex; v.ey = ey; v.ez = ez; v.ew = ew;
      tv.push_back(v);
   endtask

   // reference triple from plain modular arithmetic
   function automatic stage_t mk(input logic [31:0] x);
      stage_t t;
      longint unsigned m = 64'd1 << 32;
      longint unsigned ys = longint'(x) + 1;
      longint unsigned zs = (ys % m) + 1;
      t.x = x;
      t.y = 32'(ys % m);
      t.z = 32'(zs % m);
      t.wrap = (ys >= m) || (zs >= m);
      return t;
   endfunction

   // compare against model, then advance it with this cycle's handshakes
   task automatic model_cycle();
      int n = mq.size();
      chk("rnd_occ", 32'(occupancy), 32'(n));
      chk("rnd_in_ready", 32'(in_ready), 32'((n < 3) || out_ready));
      if (n == 0) chk("rnd_empty_ov", 32'(out_valid), 0);
      if (n == 3) chk("rnd_full_ov", 32'(out_valid), 1);
      if (out_valid && out_ready && !reset) begin
         if (n == 0) begin
            chk("rnd_spurious", 32'(out_valid), 0);
         end else begin
            chk("rnd_x", out_x, mq[0].x);
            chk("rnd_y", out_y, mq[0].y);
            chk("rnd_z", out_z, mq[0].z);
            chk("rnd_wrap", 32'(out_wrap), 32'(mq[0].wrap));
         end
      end
      if (reset) begin
         mq.delete();
      end else begin
         if (out_valid && out_ready && n > 0) void'(mq.pop_front());
         if (in_valid && in_ready) mq.push_back(mk(in_data));
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_x", out_x, 0);
      chk("rst_z", out_z, 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      // rst iv d ordy | in_ready ov occ | cd x y z wrap
      add(0,1,5,1, 1,0,0, 1,0,0,0,0);
      add(0,0,0,1, 1,0,1, 0,0,0,0,0);
      add(0,0,0,1, 1,0,1, 0,0,0,0,0);
      add(0,0,0,1, 1,1,1, 1,5,6,7,0);
      add(0,0,0,1, 1,0,0, 1,5,6,7,0);
      add(0,1,10,1, 1,0,0, 0,0,0,0,0);
      add(0,1,11,1, 1,0,1, 0,0,0,0,0);
      add(0,1,12,1, 1,0,2, 0,0,0,0,0);
      add(0,1,13,1, 1,1,3, 1,10,11,12,0);
      add(0,0,0,1, 1,1,3, 1,11,12,13,0);
      add(0,0,0,1, 1,1,2, 1,12,13,14,0);
      add(0,0,0,1, 1,1,1, 1,13,14,15,0);
      add(0,1,32'hFFFF_FFFE,1, 1,0,0, 0,0,0,0,0);
      add(0,1,32'hFFFF_FFFF,1, 1,0,1, 0,0,0,0,0);
      add(0,0,0,1, 1,0,2, 0,0,0,0,0);
      add(0,0,0,1, 1,1,2, 1,32'hFFFF_FFFE,32'hFFFF_FFFF,0,1);
      add(0,0,0,1, 1,1,1, 1,32'hFFFF_FFFF,0,1,1);
      add(0,1,1,0, 1,0,0, 1,32'hFFFF_FFFF,0,1,1);
      add(0,1,2,0, 1,0,1, 0,0,0,0,0);
      add(0,1,3,0, 1,0,2, 0,0,0,0,0);
      add(0,1,4,0, 0,1,3, 1,1,2,3,0);
      add(0,1,4,0, 0,1,3, 1,1,2,3,0);
      add(0,1,4,1, 1,1,3, 1,1,2,3,0);
      add(0,0,0,1, 1,1,3, 1,2,3,4,0);
      add(0,0,0,1, 1,1,2, 1,3,4,5,0);
      add(0,0,0,1, 1,1,1, 1,4,5,6,0);
      add(0,1,20,0, 1,0,0, 1,4,5,6,0);
      add(0,0,0,0, 1,0,1, 0,0,0,0,0);
      add(0,0,0,0, 1,0,1, 0,0,0,0,0);
      add(0,1,30,0, 1,1,1, 1,20,21,22,0);
      add(0,0,0,0, 1,1,2, 1,20,21,22,0);
      add(0,0,0,0, 1,1,2, 1,20,21,22,0);
      add(0,1,40,0, 1,1,2, 1,20,21,22,0);
      add(1,1,99,0, 0,1,3, 1,20,21,22,0);
      add(0,1,5,1, 1,0,0, 1,0,0,0,0);
      add(0,0,0,1, 1,0,1, 1,0,0,0,0);
      add(0,0,0,1, 1,0,1, 0,0,0,0,0);
      add(0,0,0,1, 1,1,1, 1,5,6,7,0);
      add(0,0,0,1, 1,0,0, 0,0,0,0,0);

      foreach (tv[i]) begin
         @(negedge clk);
         reset = tv[i].rst; in_valid = tv[i].iv;
         in_data = tv[i].d; out_ready = tv[i].ordy;
         #1;
         chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(tv[i].eir));
         chk($sformatf("row%0d_ov", i), 32'(out_valid), 32'(tv[i].eov));
         chk($sformatf("row%0d_occ", i), 32'(occupancy), 32'(tv[i].eocc));
         if (tv[i].cd) begin
            chk($sformatf("row%0d_x", i), out_x, tv[i].ex);
            chk($sformatf("row%0d_y", i), out_y, tv[i].ey);
            chk($sformatf("row%0d_z", i), out_z, tv[i].ez);
            chk($sformatf("row%0d_wrap", i), 32'(out_wrap), 32'(tv[i].ew));
         end
      end

      // random traffic with occasional resets against the queue model
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      #1;
      model_cycle();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 199) == 0);
         in_valid = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_data = ($urandom_range(0, 7) == 0) ?
                   (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
         #1;
         model_cycle();
      end

      // drain within a bounded number of cycles
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
         #1;
         model_cycle();
      end
      chk("drain_left", 32'(mq.size()), 0);
      chk("drain_occ", 32'(occupancy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
